aha_clock_select_ctrl: RTL

//  Upstream sequencer for the glitch-free clock-switch bank in the platform controller.

---
 rtl/aha_clock_select_ctrl_if.sv | 42 ++++
 rtl/aha_clock_select_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/aha_clock_select_ctrl_if.sv
// Request/ack bundle between the platform controller and the
// clock-select sequencer.
interface aha_clock_select_ctrl_if #(
  parameter int NUM_CLKS = 6
);
  logic                REQ_VALID;
  logic [2:0]          REQ_SEL;
  logic                REQ_READY;
  logic [2:0]          SELECT_REQ;
  logic [NUM_CLKS-1:0] SELECT_ACK;
  logic [2:0]          CURRENT_SEL;
  logic                DONE;
  logic                REJECT;
  logic                TIMEOUT_ERR;
  logic                ERR_CLR;

  modport master (
    output REQ_VALID,
    output REQ_SEL,
    input  REQ_READY,
    input  SELECT_REQ,
    output SELECT_ACK,
    input  CURRENT_SEL,
    input  DONE,
    input  REJECT,
    input  TIMEOUT_ERR,
    output ERR_CLR
  );

  modport slave (
    input  REQ_VALID,
    input  REQ_SEL,
    output REQ_READY,
    output SELECT_REQ,
    input  SELECT_ACK,
    output CURRENT_SEL,
    output DONE,
    output REJECT,
    output TIMEOUT_ERR,
    input  ERR_CLR
  );
endinterface

// File: rtl/aha_clock_select_ctrl.sv
// Sequencer for the glitch-free clock-switch bank: drives the select
// bus and waits for old-release then new-grant on synchronized acks.
module aha_clock_select_ctrl #(
  parameter int NUM_CLKS       = 6,
  parameter int RESET_SEL      = 0,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic CLK,
  input logic RESETn,
  aha_clock_select_ctrl_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0] RST_SEL = 3'(RESET_SEL);
  localparam logic [3:0] N_SEL = 4'(NUM_CLKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    WAIT_OLD,
    WAIT_NEW
  } state_t;

  state_t              state;
  logic [NUM_CLKS-1:0] sync_q [SYNC_STAGES];
  logic [7:0]          ack_s;
  logic [2:0]          sel_new;
  logic [2:0]          sel_old;
  logic [2:0]          select_req;
  logic [2:0]          current_sel;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_inc;
  logic                done;
  logic                reject;
  logic                timeout_err;
  logic                accept;
  logic                tmo;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.SELECT_ACK;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  // Widen to 8 so any 3-bit select indexes safely.
  always_comb begin
    ack_s = '0;
    ack_s[NUM_CLKS-1:0] = sync_q[SYNC_STAGES-1];
  end

  assign accept  = bus.REQ_VALID && (state == IDLE);
  assign tmo     = (cnt == CNT_LAST);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state       <= INIT;
      select_req  <= RST_SEL;
      current_sel <= RST_SEL;
      sel_new     <= RST_SEL;
      sel_old     <= RST_SEL;
      cnt         <= '0;
      done        <= 1'b0;
      reject      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done   <= 1'b0;
      reject <= 1'b0;
      // A timeout below overrides a same-cycle clear.
      if (bus.ERR_CLR)
        timeout_err <= 1'b0;
      unique case (state)
        INIT: begin
          if (ack_s[RST_SEL]) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        IDLE: begin
          if (accept) begin
            if ({1'b0, bus.REQ_SEL} >= N_SEL) begin
              done   <= 1'b1;
              reject <= 1'b1;
            end else if (bus.REQ_SEL == current_sel) begin
              done <= 1'b1;
            end else begin
              sel_new    <= bus.REQ_SEL;
              sel_old    <= current_sel;
              select_req <= bus.REQ_SEL;
              state      <= WAIT_OLD;
              cnt        <= '0;
            end
          end
        end
        WAIT_OLD: begin
          if (!ack_s[sel_old]) begin
            state <= WAIT_NEW;
            cnt   <= '0;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            current_sel <= sel_new;
            done        <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT_NEW: begin
          if (ack_s[sel_new]) begin
            current_sel <= sel_new;
            done        <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            current_sel <= sel_new;
            done        <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign bus.REQ_READY   = (state == IDLE);
  assign bus.SELECT_REQ  = select_req;
  assign bus.CURRENT_SEL = current_sel;
  assign bus.DONE        = done;
  assign bus.REJECT      = reject;
  assign bus.TIMEOUT_ERR = timeout_err;

endmodule
